// File: rtl/cplx_alu_pkg.sv
// cplx_alu_pkg: shared widths, ALU opcodes and sequencer state encodings
package cplx_alu_pkg;
    localparam int W  = 5;
    localparam int W2 = 2 * W;
    localparam int W3 = 2 * W + 1;
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
endpackage

// File: rtl/cplx_alu_sequencer_if.sv
// cplx_alu_sequencer_if: ALU command/result bus between the sequencer (master) and the ALU (slave)
interface cplx_alu_sequencer_if;
    import cplx_alu_pkg::*;
    logic [W-1:0]  alu_op1;
    logic [W-1:0]  alu_op2;
    logic [1:0]    alu_opcode;
    logic [W2-1:0] alu_out;
    logic          alu_valid;
    modport master (output alu_op1, alu_op2, alu_opcode, input alu_out, alu_valid);
    modport slave  (input alu_op1, alu_op2, alu_opcode, output alu_out, alu_valid);
endinterface

// File: rtl/cplx_result_collector.sv
// cplx_result_collector: captures ALU results in issue order, watches for ALU timeout, combines the complex result
module cplx_result_collector
    import cplx_alu_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          issue,
    input  logic          mul,
    input  logic          conj,
    input  logic [W2-1:0] alu_out,
    input  logic          alu_valid,
    output logic          fin,
    output logic          res_valid,
    output logic [W3-1:0] res_re,
    output logic [W3-1:0] res_im,
    output logic          err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [2:0]    pending;
    logic [1:0]    sidx;
    logic [CW-1:0] cnt;
    logic [W2-1:0] s0, s1, s2;
    logic          cap, last, tmo;
    logic [W3-1:0] z0, z1, z2, z3, cre, cim;
    assign cap  = alu_valid && pending != 3'd0;
    assign last = cap && sidx == (mul ? 2'd3 : 2'd1);
    assign tmo  = pending != 3'd0 && !alu_valid && cnt == CW'(TIMEOUT);
    assign fin  = last || tmo;
    // the final product p3 (or the im sum) is combined straight off the bus on its capture edge
    assign z0  = {1'b0, s0};
    assign z1  = {1'b0, s1};
    assign z2  = {1'b0, s2};
    assign z3  = {1'b0, alu_out};
    assign cre = mul ? (conj ? z0 + z1 : z0 - z1) : z0;
    assign cim = mul ? (conj ? z3 - z2 : z2 + z3) : z3;
    // slot capture, outstanding-op count, timeout watchdog and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending   <= '0;
            sidx      <= '0;
            cnt       <= '0;
            s0        <= '0;
            s1        <= '0;
            s2        <= '0;
            res_valid <= 1'b0;
            res_re    <= '0;
            res_im    <= '0;
            err       <= 1'b0;
        end else begin
            res_valid <= fin;
            pending   <= pending + 3'(issue) - 3'(cap);
            cnt       <= (alu_valid || clear) ? '0 : (pending != 3'd0 ? cnt + 1'b1 : cnt);
            if (cap) sidx <= sidx + 2'd1;
            if (cap && sidx == 2'd0) s0 <= alu_out;
            if (cap && sidx == 2'd1) s1 <= alu_out;
            if (cap && sidx == 2'd2) s2 <= alu_out;
            if (clear) begin
                err  <= 1'b0;
                sidx <= '0;
            end
            if (last) begin
                res_re <= cre;
                res_im <= cim;
                sidx   <= '0;
            end
            if (tmo) begin
                res_re  <= '0;
                res_im  <= '0;
                err     <= 1'b1;
                pending <= '0;
                sidx    <= '0;
                cnt     <= '0;
            end
        end
    end
endmodule

// File: rtl/cplx_alu_sequencer.sv
// cplx_alu_sequencer: splits a complex add/sub/mul into real ALU ops; CPLX_SEQ_CONJ_EN adds conj_b (use conj(b))
module cplx_alu_sequencer
    import cplx_alu_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    cop,
    input  logic [W-1:0]  a_re,
    input  logic [W-1:0]  a_im,
    input  logic [W-1:0]  b_re,
    input  logic [W-1:0]  b_im,
`ifdef CPLX_SEQ_CONJ_EN
    input  logic          conj_b,
`endif
    output logic          busy,
    output logic          res_valid,
    output logic [W3-1:0] res_re,
    output logic [W3-1:0] res_im,
    output logic          err,
    cplx_alu_sequencer_if.master alu
);
    state_t       state;
    logic [1:0]   idx, op_q;
    logic [W-1:0] ar, ai, br, bi;
    logic         conj_q, conj_in, accept, issue, fin, mul_q, last_op;
`ifdef CPLX_SEQ_CONJ_EN
    assign conj_in = conj_b;
`else
    assign conj_in = 1'b0;
`endif
    assign accept  = state == ST_IDLE && start && cop != OP_NOP;
    assign issue   = accept || state == ST_ISSUE;
    assign mul_q   = op_q == OP_MUL;
    assign last_op = idx == (mul_q ? 2'd3 : 2'd1);
    assign busy    = state != ST_IDLE;
    // FSM and issue path: op0 goes out on the accept edge, the rest from the latched operands
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            idx            <= '0;
            op_q           <= OP_NOP;
            conj_q         <= 1'b0;
            ar             <= '0;
            ai             <= '0;
            br             <= '0;
            bi             <= '0;
            alu.alu_op1    <= '0;
            alu.alu_op2    <= '0;
            alu.alu_opcode <= OP_NOP;
        end else if (fin) begin
            state          <= ST_IDLE;
            alu.alu_opcode <= OP_NOP;
        end else if (accept) begin
            state          <= ST_ISSUE;
            idx            <= 2'd1;
            op_q           <= cop;
            conj_q         <= conj_in;
            ar             <= a_re;
            ai             <= a_im;
            br             <= b_re;
            bi             <= b_im;
            alu.alu_op1    <= a_re;
            alu.alu_op2    <= b_re;
            alu.alu_opcode <= cop;
        end else if (state == ST_ISSUE) begin
            alu.alu_op1    <= idx[0] ? ai : ar;
            alu.alu_op2    <= (idx[0] ^ idx[1]) ? bi : br;
            alu.alu_opcode <= mul_q ? OP_MUL : (conj_q ? op_q ^ 2'b11 : op_q);
            idx            <= idx + 2'd1;
            state          <= last_op ? ST_DRAIN : ST_ISSUE;
        end else if (state == ST_DRAIN) begin
            alu.alu_opcode <= OP_NOP;
        end
    end
    cplx_result_collector #(.TIMEOUT(TIMEOUT)) u_coll (
        .clk       (clk),
        .reset     (reset),
        .clear     (accept),
        .issue     (issue),
        .mul       (mul_q),
        .conj      (conj_q),
        .alu_out   (alu.alu_out),
        .alu_valid (alu.alu_valid),
        .fin       (fin),
        .res_valid (res_valid),
        .res_re    (res_re),
        .res_im    (res_im),
        .err       (err)
    );
endmodule

// File: tb/tb_cplx_alu_sequencer.sv
// tb_cplx_alu_sequencer: directed vectors against a one-cycle-latency ALU model
module tb_cplx_alu_sequencer;
    import cplx_alu_pkg::*;
    logic          clk = 0, reset = 1, start = 0, conj_b = 0, alu_en = 1;
    logic [1:0]    cop = OP_NOP;
    logic [W-1:0]  a_re = 0, a_im = 0, b_re = 0, b_im = 0;
    logic          busy, res_valid, err;
    logic [W3-1:0] res_re, res_im;
    int            total = 0, bad = 0;
    cplx_alu_sequencer_if alu_bus();
    cplx_alu_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cop       (cop),
        .a_re      (a_re),
        .a_im      (a_im),
        .b_re      (b_re),
        .b_im      (b_im),
`ifdef CPLX_SEQ_CONJ_EN
        .conj_b    (conj_b),
`endif
        .busy      (busy),
        .res_valid (res_valid),
        .res_re    (res_re),
        .res_im    (res_im),
        .err       (err),
        .alu       (alu_bus)
    );
    always #5 clk = ~clk;
    // ALU responder: one-edge latency, 10-bit wrap; alu_en=0 models a dead ALU
    always @(posedge clk) begin
        if (reset) alu_bus.alu_valid <= 1'b0;
        else alu_bus.alu_valid <= alu_en && alu_bus.alu_opcode != OP_NOP;
        case (alu_bus.alu_opcode)
            OP_ADD:  alu_bus.alu_out <= W2'(alu_bus.alu_op1) + W2'(alu_bus.alu_op2);
            OP_SUB:  alu_bus.alu_out <= W2'(alu_bus.alu_op1) - W2'(alu_bus.alu_op2);
            default: alu_bus.alu_out <= W2'(alu_bus.alu_op1) * W2'(alu_bus.alu_op2);
        endcase
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic run(input string tag, input logic [1:0] c, input int xr, xi, yr, yi,
                       input logic cj, pk, input int e_lat, e_re, e_im, e_err, e_ops);
        int lat, ops;
        logic [W3-1:0] held;
        cop = c;
        a_re = W'(xr);
        a_im = W'(xi);
        b_re = W'(yr);
        b_im = W'(yi);
        conj_b = cj;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        lat = 99;
        ops = int'(alu_bus.alu_opcode != OP_NOP);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (pk && k == 2) begin
                start = 1;
                cop = OP_ADD;
            end
            if (k == 3) start = 0;
            if (res_valid) begin
                lat = k;
                break;
            end
            ops += int'(alu_bus.alu_opcode != OP_NOP);
        end
        check({tag, "_lat"}, lat, e_lat);
        check({tag, "_re"}, 32'(res_re), e_re);
        check({tag, "_im"}, 32'(res_im), e_im);
        check({tag, "_err"}, 32'(err), e_err);
        check({tag, "_ops"}, ops, e_ops);
        check({tag, "_busy"}, 32'(busy), 0);
        held = res_re;
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(res_valid), 0);
        check({tag, "_hold"}, 32'(res_re), 32'(held));
    endtask
    initial begin
        int strobes;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(res_valid), 0);
        check("rst_re", 32'(res_re), 0);
        check("rst_im", 32'(res_im), 0);
        check("rst_err", 32'(err), 0);
        check("rst_opc", 32'(alu_bus.alu_opcode), 0);
        reset = 0;
        @(posedge clk); #1;
        run("mul", OP_MUL, 3, 4, 5, 2, 0, 0, 5, 7, 26, 0, 4);
        run("sub", OP_SUB, 10, 3, 4, 7, 0, 0, 3, 6, 1020, 0, 2);
        run("mul31", OP_MUL, 0, 31, 0, 31, 0, 0, 5, 1087, 0, 0, 4);
        run("add31", OP_ADD, 31, 31, 31, 31, 0, 0, 3, 62, 62, 0, 2);
        alu_en = 0;
        run("tmo", OP_MUL, 3, 4, 5, 2, 0, 1, 9, 0, 0, 1, 4);
        alu_en = 1;
        repeat (2) @(posedge clk);
        #1;
        check("tmo_err_hold", 32'(err), 1);
        check("tmo_idle", 32'(busy), 0);
        run("add_clr", OP_ADD, 1, 2, 4, 8, 0, 0, 3, 5, 10, 0, 2);
        cop = OP_NOP;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        check("nop_busy", 32'(busy), 0);
        check("nop_opc", 32'(alu_bus.alu_opcode), 0);
        cop = OP_MUL;
        a_re = 3; a_im = 4; b_re = 5; b_im = 2;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_opc", 32'(alu_bus.alu_opcode), 0);
        @(posedge clk); #1;
        reset = 0;
        strobes = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            strobes += int'(res_valid);
        end
        check("abort_novalid", strobes, 0);
        run("add_after", OP_ADD, 1, 2, 4, 8, 0, 0, 3, 5, 10, 0, 2);
`ifdef CPLX_SEQ_CONJ_EN
        run("cmul", OP_MUL, 3, 4, 5, 2, 1, 0, 5, 23, 14, 0, 4);
        run("cadd", OP_ADD, 10, 7, 4, 3, 1, 0, 3, 14, 4, 0, 2);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cplx_alu_sequencer.md
Name: cplx_alu_sequencer

Overview:
- Initiator side of the 5-bit ALU command interface (alu_op1/alu_op2/alu_opcode out, alu_out/alu_valid in).
- Accepts one complex operation (add, sub or mul on a = a_re + j·a_im and b = b_re + j·b_im) and breaks it into real ALU ops issued one per cycle.
- Collects ALU results in issue order and combines them into a complex result.
- Sits between the complex-number front end and the ALU; the ALU is the responder.

Parameters:
- W, 5, operand width; must match ALU operand width.
- TIMEOUT, 8, consecutive cycles without alu_valid while results are pending before an error is flagged.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- cop  input  2  01=sub, 10=add, 11=mul; 00 ignored.
- a_re, a_im, b_re, b_im  input  W each  unsigned operands.
- busy  output  1  operation in progress.
- res_valid  output  1  one-cycle result strobe.
- res_re, res_im  output  2W+1 each  result, 11-bit two's-complement wrap.
- err  output  1  qualifies res_valid: ALU timeout.
- alu_op1, alu_op2  output  W each  registered ALU operands.
- alu_opcode  output  2  registered ALU opcode; 00 when not issuing.
- alu_out  input  2W  ALU result.
- alu_valid  input  1  ALU result valid.

Behaviour:
- Reset, asynchronous and active-high: all outputs 0; alu_opcode=00; state IDLE; pending=0; timeout counter=0. A reset mid-operation aborts it and produces no res_valid.
- States: IDLE → ISSUE → DRAIN → IDLE.
- Acceptance: E0 is the rising edge where state=IDLE, start=1 and cop≠00. At E0, operands and cop are latched, busy=1 and the first op is driven. cop=00 or start while busy is ignored.
- Issue order, one op per cycle on successive edges:
  - add/sub: (a_re,b_re), (a_im,b_im), both with opcode=cop.
  - mul: (a_re,b_re)=p0, (a_im,b_im)=p1, (a_re,b_im)=p2, (a_im,b_re)=p3, opcode 11.
- After the last op, alu_opcode=00 and state=DRAIN.
- ALU latency is one edge. Each edge with pending>0 and alu_valid=1 captures alu_out into the next result slot. alu_valid while pending=0 is ignored.
- Combine, at the edge the last result is captured:
  - add/sub: res = zero-extended alu_out.
  - mul: res_re = p0 − p1, res_im = p2 + p3, both 11-bit wrap.
- At that edge res_valid=1 for one cycle, busy=0 and state=IDLE.
- Latency with an ideal ALU: add/sub res_valid at E3; mul at E5. A new start may be accepted on the edge after res_valid.
- res_re/res_im hold until the next res_valid.
- Timeout: the counter increments on each edge with pending>0 and alu_valid=0, and clears on alu_valid. On reaching TIMEOUT: err=1, res_valid=1, res=0, IDLE. err clears at the next accepted start.

Optional Feature:
- CPLX_SEQ_CONJ_EN defined: adds input conj_b (1 bit, latched at E0). When conj_b=1, b is replaced by conj(b):
  - add/sub: the im op uses the opposite opcode (add↔sub).
  - mul: res_re = p0 + p1, res_im = p3 − p2.
- Undefined: no conj_b port; behaviour as above.

Decomposition:
- Shared package cplx_alu_pkg holds the opcode constants (OP_NOP, OP_SUB, OP_ADD, OP_MUL), the state enum, and width localparams (W, 2W, 2W+1).
- One sub-module, cplx_result_collector: slot capture, pending count, timeout counter and combine arithmetic.
- The top level holds the FSM and the issue path.

Test Plan:
- mul with a=3+4j, b=5+2j, real ALU attached → res_valid at E5, res_re=7, res_im=26, err=0; ALU sees opcode 11 on four consecutive edges.
- sub with a=10+3j, b=4+7j → res_valid at E3, res_re=6, res_im=1020 (ALU 10-bit wrap), err=0.
- mul with a=0+31j, b=0+31j → res_re=1087 (−961), res_im=0; add with 31+31j plus 31+31j → 62, 62.
- Bench ALU model holds alu_valid=0; mul start → err=1 and res_valid at E9, res=0, busy=0. start pulsed while busy and cop=00 in IDLE are both ignored.
- reset asserted at E2 of a mul → immediately busy=0 and alu_opcode=00, no res_valid; next add completes normally.
- With CPLX_SEQ_CONJ_EN, conj_b=1: mul 3+4j × conj(5+2j) → 23, 14; add 10+7j + conj(4+3j) → 14, 4.
